dma_sram_arbiter: RTL and testbench

// - Block-copy DMA engine plus single-port SRAM arbiter between the CPU controller and the DMA.
// - CPU has strict priority. DMA only uses the port in cycles where cpu_req=0.
// - Copies dma_len 32-bit words from dma_src to dma_dst, ascending addresses, one word at a time.
// - Sits between the CPU controller's SRAM port and the SRAM instance inside the SP top.

---
 rtl/dma_sram_arbiter_pkg.sv | 13 +
 rtl/dma_sram_arbiter.sv | 106 ++++++++++
 tb/tb_dma_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_sram_arbiter_pkg.sv
// Shared types for the DMA block-copy engine and its SRAM port arbiter.
// Holds the 3-bit DMA state encoding used by the engine FSM.
package dma_sram_arbiter_pkg;

    typedef enum logic [2:0] {
        DMA_STATE_IDLE = 3'd0,
        DMA_STATE_RD   = 3'd1,
        DMA_STATE_CAP  = 3'd2,
        DMA_STATE_WR   = 3'd3,
        DMA_STATE_DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_sram_arbiter.sv
// Block-copy DMA sharing a single-port SRAM with the CPU; the CPU always wins the port.
// 3 cycles per word + 1 DONE cycle uncontended; each cpu_req cycle in RD/WR stalls DMA one cycle.
module dma_sram_arbiter
    import dma_sram_arbiter_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_di,
    input  logic            cpu_we,
    input  logic            dma_start,
    input  logic [AW-1:0]   dma_src,
    input  logic [AW-1:0]   dma_dst,
    input  logic [LENW-1:0] dma_len,
    input  logic [DW-1:0]   sram_DO,
    output logic [AW-1:0]   sram_ADDR,
    output logic [DW-1:0]   sram_DI,
    output logic            sram_EN,
    output logic            sram_WE,
    output logic            dma_busy,
    output logic            dma_done,
    output logic [LENW-1:0] dma_remaining
);

    dma_state_e      state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [DW-1:0]   buf_q, buf_d;

    logic            dma_grant;
    logic            dma_wr;
    logic [AW-1:0]   dma_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DMA_STATE_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        case (state_q)
            DMA_STATE_IDLE: begin
                if (dma_start) begin
                    src_d   = dma_src;
                    dst_d   = dma_dst;
                    rem_d   = dma_len;
                    state_d = (dma_len != '0) ? DMA_STATE_RD : DMA_STATE_DONE;
                end
            end
            DMA_STATE_RD: begin
                if (!cpu_req) state_d = DMA_STATE_CAP;
            end
            DMA_STATE_CAP: begin
                // Read data for the address issued in RD arrives now, even if the CPU owns the port.
                buf_d   = sram_DO;
                state_d = DMA_STATE_WR;
            end
            DMA_STATE_WR: begin
                if (!cpu_req) begin
                    src_d   = src_q + AW'(1);
                    dst_d   = dst_q + AW'(1);
                    rem_d   = rem_q - LENW'(1);
                    state_d = (rem_q == LENW'(1)) ? DMA_STATE_DONE : DMA_STATE_RD;
                end
            end
            DMA_STATE_DONE: state_d = DMA_STATE_IDLE;
            default:        state_d = DMA_STATE_IDLE;
        endcase
    end

    always_comb begin
        dma_wr    = (state_q == DMA_STATE_WR);
        dma_grant = !cpu_req && ((state_q == DMA_STATE_RD) || dma_wr);
        dma_addr  = dma_wr ? dst_q : src_q;
        dma_busy  = (state_q == DMA_STATE_RD) || (state_q == DMA_STATE_CAP) || dma_wr;
        dma_done  = (state_q == DMA_STATE_DONE);
    end

    assign sram_EN       = cpu_req | dma_grant;
    assign sram_ADDR     = cpu_req ? cpu_addr : (dma_grant ? dma_addr : '0);
    assign sram_DI       = cpu_req ? cpu_di : ((dma_grant && dma_wr) ? buf_q : '0);
    assign sram_WE       = cpu_req ? cpu_we : (dma_grant && dma_wr);
    assign dma_remaining = rem_q;

endmodule

// File: tb/tb_dma_sram_arbiter.sv
// Bench for dma_sram_arbiter: behavioural SRAM, mux vector table, scoreboarded DMA writes and CPU reads.
module tb_dma_sram_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LENW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_di;
    logic            cpu_we;
    logic            dma_start;
    logic [AW-1:0]   dma_src;
    logic [AW-1:0]   dma_dst;
    logic [LENW-1:0] dma_len;
    logic [DW-1:0]   sram_DO;
    logic [AW-1:0]   sram_ADDR;
    logic [DW-1:0]   sram_DI;
    logic            sram_EN;
    logic            sram_WE;
    logic            dma_busy;
    logic            dma_done;
    logic [LENW-1:0] dma_remaining;

    dma_sram_arbiter #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_we(cpu_we),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .sram_DO(sram_DO), .sram_ADDR(sram_ADDR), .sram_DI(sram_DI),
        .sram_EN(sram_EN), .sram_WE(sram_WE),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_remaining(dma_remaining)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];

    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE) mem[sram_ADDR] <= sram_DI;
            sram_DO <= mem[sram_ADDR];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [AW+DW-1:0] dma_q[$];
    logic [DW-1:0]    cpu_q[$];
    logic [LENW-1:0]  rem_seq[$];
    int               wr_cnt  = 0;
    logic             rd_pend = 1'b0;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (cpu_q.size() == 0) chk("cpu_rd_unexpected", 64'(sram_DO), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("cpu_rd_data", 64'(sram_DO), 64'(cpu_q.pop_front()));
        end
        rd_pend = cpu_req && !cpu_we;
        if (sram_EN && sram_WE && !cpu_req && !reset) begin
            wr_cnt++;
            if (dma_q.size() == 0) chk("dma_wr_unexpected", 64'({sram_ADDR, sram_DI}), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("dma_wr_addr_data", 64'({sram_ADDR, sram_DI}), 64'(dma_q.pop_front()));
        end
    end

    task automatic start_dma(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LENW-1:0] l);
        @(posedge clk); #1;
        dma_src = s; dma_dst = d; dma_len = l; dma_start = 1'b1;
        @(posedge clk); #1;
        dma_start = 1'b0;
    endtask

    logic xfer_done;

    // Called in the first cycle after the start edge; returns the cycle index of dma_done.
    task automatic run_xfer(output int cyc);
        logic [LENW-1:0] prev;
        cyc = 1;
        xfer_done = 1'b0;
        prev = 16'hFFFF;
        rem_seq.delete();
        while (!xfer_done && cyc < 400) begin
            @(negedge clk);
            if (dma_remaining !== prev) rem_seq.push_back(dma_remaining);
            prev = dma_remaining;
            if (dma_done) xfer_done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!xfer_done) chk("done_timeout", 0, 1);
        xfer_done = 1'b1;
    endtask

    typedef struct {
        logic req; logic we; logic [AW-1:0] addr; logic [DW-1:0] di;
        logic e_en; logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_di; logic [DW-1:0] e_do;
    } vec_t;
    vec_t vt[8];

    initial begin
        int cyc;
        int k;
        vt[0] = '{1'b0, 1'b0, 16'h1234, 32'h55,        1'b0, 1'b0, 16'h0000, 32'h0,         32'h0};
        vt[1] = '{1'b0, 1'b1, 16'h1234, 32'h55,        1'b0, 1'b0, 16'h0000, 32'h0,         32'h0};
        vt[2] = '{1'b1, 1'b1, 16'h5000, 32'h1234_5678, 1'b1, 1'b1, 16'h5000, 32'h1234_5678, 32'h0};
        vt[3] = '{1'b1, 1'b0, 16'h5000, 32'h0,         1'b1, 1'b0, 16'h5000, 32'h0,         32'h1234_5678};
        vt[4] = '{1'b1, 1'b0, 16'h0010, 32'hABCD,      1'b1, 1'b0, 16'h0010, 32'hABCD,      32'hCAFE_0010};
        vt[5] = '{1'b1, 1'b1, 16'h5001, 32'h9ABC_DEF0, 1'b1, 1'b1, 16'h5001, 32'h9ABC_DEF0, 32'h0};
        vt[6] = '{1'b1, 1'b0, 16'h5001, 32'h7,         1'b1, 1'b0, 16'h5001, 32'h7,         32'h9ABC_DEF0};
        vt[7] = '{1'b0, 1'b0, 16'h5001, 32'h7,         1'b0, 1'b0, 16'h0000, 32'h0,         32'h0};

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 32'hCAFE_0010;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0100 + i] = 32'(i + 1);
            mem[16'h0300 + i] = 32'hDEAD_0000 + 32'(i);
        end
        mem[16'hFFFF] = 32'h1111_FFFF;
        mem[16'h0000] = 32'h2222_0000;

        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_di = '0; cpu_we = 1'b0;
        dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_en", 64'(sram_EN), 0);
        chk("reset_busy", 64'(dma_busy), 0);
        chk("reset_done", 64'(dma_done), 0);
        chk("reset_remaining", 64'(dma_remaining), 0);

        // Arbiter mux with the DMA idle.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            cpu_req = vt[i].req; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_di = vt[i].di;
            if (vt[i].req && !vt[i].we) cpu_q.push_back(vt[i].e_do);
            @(negedge clk);
            chk($sformatf("vec%0d_en", i), 64'(sram_EN), 64'(vt[i].e_en));
            chk($sformatf("vec%0d_we", i), 64'(sram_WE), 64'(vt[i].e_we));
            chk($sformatf("vec%0d_addr", i), 64'(sram_ADDR), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d_di", i), 64'(sram_DI), 64'(vt[i].e_di));
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Uncontended 4-word copy.
        for (int i = 0; i < 4; i++) dma_q.push_back({16'h0200 + 16'(i), 32'(i + 1)});
        start_dma(16'h0100, 16'h0200, 16'd4);
        run_xfer(cyc);
        chk("copy_done_latency", 64'(cyc), 13);
        chk("copy_rem_seq_len", 64'(rem_seq.size()), 5);
        for (int i = 0; i < 5 && i < rem_seq.size(); i++)
            chk($sformatf("copy_rem_seq%0d", i), 64'(rem_seq[i]), 64'(4 - i));
        for (int i = 0; i < 4; i++)
            chk($sformatf("copy_mem%0d", i), 64'(mem[16'h0200 + i]), 64'(i + 1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("copy_done_pulse_width", 64'(dma_done), 0);

        // Same copy with the CPU reading 0x10 every other cycle.
        for (int i = 0; i < 4; i++) dma_q.push_back({16'h0210 + 16'(i), 32'(i + 1)});
        start_dma(16'h0100, 16'h0210, 16'd4);
        k = 0;
        fork
            run_xfer(cyc);
            begin
                while (!xfer_done && k < 400) begin
                    cpu_req = ~cpu_req; cpu_addr = 16'h0010; cpu_we = 1'b0;
                    if (cpu_req) cpu_q.push_back(32'hCAFE_0010);
                    k++;
                    @(posedge clk); #1;
                end
                cpu_req = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("alt_slower", 64'(cyc > 13), 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_mem%0d", i), 64'(mem[16'h0210 + i]), 64'(i + 1));
        chk("alt_cpu_reads_drained", 64'(cpu_q.size()), 0);

        // Zero-length start.
        start_dma(16'h0100, 16'h0500, 16'd0);
        @(negedge clk);
        chk("len0_done", 64'(dma_done), 1);
        chk("len0_busy", 64'(dma_busy), 0);
        chk("len0_en", 64'(sram_EN), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("len0_done_once", 64'(dma_done), 0);
        chk("len0_no_write", 64'(mem[16'h0500]), 0);

        // Reset after two words of a 4-word copy.
        for (int i = 0; i < 4; i++) dma_q.push_back({16'h0300 + 16'(i), 32'(i + 1)});
        k = wr_cnt;
        start_dma(16'h0100, 16'h0300, 16'd4);
        cyc = 0;
        while (wr_cnt < k + 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 100) chk("abort_wait_timeout", 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dma_q.delete();
        @(negedge clk);
        chk("abort_busy", 64'(dma_busy), 0);
        chk("abort_remaining", 64'(dma_remaining), 0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_mem0", 64'(mem[16'h0300]), 1);
        chk("abort_mem1", 64'(mem[16'h0301]), 2);
        chk("abort_mem2", 64'(mem[16'h0302]), 64'h0000_0000_DEAD_0002);
        chk("abort_mem3", 64'(mem[16'h0303]), 64'h0000_0000_DEAD_0003);

        // Address wrap, plus a second start while busy that must be ignored.
        dma_q.push_back({16'h0010, 32'h1111_FFFF});
        dma_q.push_back({16'h0011, 32'h2222_0000});
        start_dma(16'hFFFF, 16'h0010, 16'd2);
        dma_src = 16'h0100; dma_dst = 16'h0400; dma_len = 16'd4; dma_start = 1'b1;
        @(posedge clk); #1;
        dma_start = 1'b0;
        @(negedge clk);
        chk("wrap_restart_ignored_rem", 64'(dma_remaining), 2);
        chk("wrap_busy", 64'(dma_busy), 1);
        @(posedge clk); #1;
        run_xfer(cyc);
        repeat (10) @(posedge clk);
        #1;
        chk("wrap_mem10", 64'(mem[16'h0010]), 64'h0000_0000_1111_FFFF);
        chk("wrap_mem11", 64'(mem[16'h0011]), 64'h0000_0000_2222_0000);
        chk("wrap_no_second_copy", 64'(mem[16'h0400]), 0);
        chk("wrap_idle_after", 64'(dma_busy), 0);

        chk("dma_writes_drained", 64'(dma_q.size()), 0);
        chk("cpu_reads_drained", 64'(cpu_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
